// File: rtl/instr_fetch_pkg.sv
// Shared widths, reset PC, FSM state encoding and instruction field positions
// for the byte-serial instruction fetch unit.
package instr_fetch_pkg;

    localparam int IF_ADDR_W  = 11;
    localparam int IF_DATA_W  = 24;
    localparam int IF_INSTR_W = 28;
    localparam logic [IF_ADDR_W-1:0] IF_RESET_PC = 11'd1024;

    localparam int BYTES_PER_INSTR = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CAP  = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    // Instruction layout {opcode5, Rs5, Rt5, Rd5, imm8}
    localparam int OPC_LSB = 23;
    localparam int OPC_W   = 5;
    localparam int RS_LSB  = 18;
    localparam int RT_LSB  = 13;
    localparam int RD_LSB  = 8;
    localparam int REG_W   = 5;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 8;

endpackage

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: reads four bytes per instruction from a
// registered-read memory, assembles them big-endian and holds until accepted.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W  = IF_ADDR_W,
    parameter int DATA_W  = IF_DATA_W,
    parameter int INSTR_W = IF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_new,
    output logic               memread,
    output logic [ADDR_W-1:0]  address,
    input  logic [DATA_W-1:0]  memdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               busy
);

    fetch_state_t       state_reg;
    logic [ADDR_W-1:0]  pc_reg;
    logic [1:0]         k_reg;
    logic [INSTR_W-1:0] byte_sr_reg;

    logic [ADDR_W-1:0]  pc_load_target;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  byte_addr_next;
    logic [1:0]         k_inc;
    logic               unused_memdata;

    assign pc_load_target = {pc_new[ADDR_W-1:2], 2'b00};
    assign pc_plus4       = pc_reg + ADDR_W'(4);
    assign k_inc          = k_reg + 2'd1;
    assign byte_addr_next = pc_reg + ADDR_W'(k_inc);
    assign busy           = (state_reg != ST_IDLE);
    // Only the low byte of each memory word carries instruction data.
    assign unused_memdata = ^memdata[DATA_W-1:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= RESET_PC;
            k_reg       <= 2'd0;
            byte_sr_reg <= '0;
            memread     <= 1'b0;
            address     <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (pc_load) begin
            pc_reg      <= pc_load_target;
            k_reg       <= 2'd0;
            instr_valid <= 1'b0;
            if (fetch_en) begin
                state_reg <= ST_REQ;
                memread   <= 1'b1;
                address   <= pc_load_target;
            end else begin
                state_reg <= ST_IDLE;
                memread   <= 1'b0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (fetch_en) begin
                        k_reg     <= 2'd0;
                        state_reg <= ST_REQ;
                        memread   <= 1'b1;
                        address   <= pc_reg;
                    end
                end
                ST_REQ: begin
                    memread   <= 1'b0;
                    state_reg <= ST_CAP;
                end
                ST_CAP: begin
                    // Shifting left drops b0[7:4] once all four bytes are in.
                    byte_sr_reg <= {byte_sr_reg[INSTR_W-9:0], memdata[7:0]};
                    k_reg       <= k_inc;
                    if (k_reg == 2'd3) begin
                        state_reg <= ST_HOLD;
                    end else begin
                        state_reg <= ST_REQ;
                        memread   <= 1'b1;
                        address   <= byte_addr_next;
                    end
                end
                ST_HOLD: begin
                    if (!instr_valid) begin
                        instr       <= byte_sr_reg;
                        instr_pc    <= pc_reg;
                        instr_valid <= 1'b1;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc_reg      <= pc_plus4;
                        k_reg       <= 2'd0;
                        if (fetch_en) begin
                            state_reg <= ST_REQ;
                            memread   <= 1'b1;
                            address   <= pc_plus4;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
